serial_subtractor_ctrl: RTL and testbench
=========================================

# serial_subtractor_ctrl

Bit-serial multi-bit subtractor: a controller that sequences a single 1-bit subtract cell (difference plus borrow flip-flop) over WIDTH cycles to compute d = a − b on unsigned operands. It sits beside the combinational half/full subtractor blocks in the basic-logic library. It trades latency for area by reusing one cell, and gives the team its reference start/busy/done handshake.

## Interface

Parameters:
- WIDTH, 8, operand/result width in bits; legal range ≥ 1.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge only.
- b  input  WIDTH  subtrahend; captured on the accepting edge only.
- busy  output  1  high while bits are being processed (RUN state).
- done  output  1  one-cycle pulse when the result is valid.
- d  output  WIDTH  registered difference, a − b mod 2^WIDTH.
- borrow  output  1  registered final borrow; 1 if and only if a < b (unsigned).

## Operation

- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - If start=1, load a_sh←a, b_sh←b, res_sh←0, br←0, cnt←0, and go to RUN.
  - If start=0, stay in IDLE.
- RUN, one bit per cycle, LSB first:
  - Cell: x=a_sh[0], y=b_sh[0].
  - diff = x ^ y ^ br.
  - br_next = (~x & y) | (~(x ^ y) & br).
  - a_sh and b_sh shift right 1. res_sh shifts right 1 with diff inserted at bit WIDTH−1. br←br_next. cnt←cnt+1.
  - When cnt = WIDTH−1 on this edge (last bit): load d←final shifted result and borrow←br_next, then go to DONE.
- DONE: done=1 for this cycle only, then go unconditionally to IDLE.
- start is ignored in RUN and DONE. Operand inputs may change freely after acceptance without affecting the result.
- d and borrow hold the last completed result until the next completion. They never show partial results.
- cnt width is max(1, clog2(WIDTH)) bits. It never wraps within an operation.
- WIDTH=1 degenerates to a registered half subtractor: d = a ^ b, borrow = ~a & b.

## Timing

- Reset values: state=IDLE, busy=0, done=0, d=0, borrow=0; internal registers all 0.
- Reset has priority over every other action. Asserting rst in RUN or DONE aborts the operation: no done pulse, and d/borrow are cleared to 0.
- Cycle numbering: start=1 in IDLE is accepted at edge E0.
  - busy=1 from after E0 through E(WIDTH), i.e. exactly WIDTH cycles.
  - Bit i is processed at edge E(i+1).
  - d/borrow update at edge E(WIDTH).
  - done=1 with busy=0 in the cycle following E(WIDTH).
  - IDLE is re-entered at E(WIDTH+1).
- Latency from the accepting edge to the done cycle: WIDTH+1 cycles. Maximum throughput: one operation every WIDTH+2 cycles (start held high continuously).
- busy and done are never high together. done is never high for 2 consecutive cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan

- WIDTH=8, a=0x5A, b=0x3C, 1-cycle start → busy high 8 cycles, then done pulse; d=0x1E, borrow=0.
- WIDTH=8, a=0x00, b=0x01 → d=0xFF, borrow=1. Then a=0xFF, b=0xFF → d=0x00, borrow=0. Then a=0x80, b=0x7F → d=0x01, borrow=0.
- WIDTH=8, start a=0x10, b=0x01. At cycle 3 of RUN, pulse start with a=0xAA, b=0x55 and also change the a/b inputs → second request ignored; result d=0x0F, borrow=0; exactly one done pulse.
- WIDTH=8, start held high continuously with fixed a=0x64, b=0x32 → done pulses every 10 cycles, each with d=0x32, borrow=0.
- WIDTH=8, rst asserted for 1 cycle at RUN cycle 4 → next cycle busy=0, done=0, d=0, borrow=0, no done pulse. A fresh start then completes normally.
- WIDTH=1, all four (a,b) combinations → (0,0)→d=0,b=0; (0,1)→d=1,b=1; (1,0)→d=1,b=0; (1,1)→d=0,b=0; each with done 2 cycles after the accepting edge. WIDTH=16 random sweep of ≥1000 vectors against {borrow, d} = a − b.

Source files
------------

// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl
//   Bit-serial unsigned subtractor d = a - b. One 1-bit subtract cell with a
//   borrow flip-flop is reused over WIDTH cycles, LSB first, under a
//   start/busy/done handshake.
//
// Ports
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous active-high reset
//   start   in   1      request, sampled only while idle
//   a       in   WIDTH  minuend, captured on the accepting edge
//   b       in   WIDTH  subtrahend, captured on the accepting edge
//   busy    out  1      high while bits are being processed
//   done    out  1      one-cycle pulse, d/borrow valid
//   d       out  WIDTH  registered difference, a - b mod 2^WIDTH
//   borrow  out  1      registered final borrow (a < b)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands loaded on the accepting edge
// RUN   | one bit per cycle through the subtract cell, WIDTH cycles
// DONE  | done pulse for one cycle, then back to IDLE

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             borrow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_sh, b_sh, res_sh;
    logic [CW-1:0]    cnt;
    logic             br;

    logic             x, y, diff, br_next, last_bit;
    logic [WIDTH-1:0] res_next;

    // Subtract cell and result shift. Shifting the whole register and then
    // overwriting the MSB keeps the expression valid for WIDTH=1.
    always_comb begin
        x        = a_sh[0];
        y        = b_sh[0];
        diff     = x ^ y ^ br;
        br_next  = (~x & y) | (~(x ^ y) & br);
        res_next = res_sh >> 1;
        res_next[WIDTH-1] = diff;
        last_bit = (cnt == CNT_LAST);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode straight from the state register, so they are glitch-free
    // registered signals with no path from the inputs.
    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            d      <= '0;
            borrow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        res_sh <= '0;
                        br     <= 1'b0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    res_sh <= res_next;
                    br     <= br_next;
                    // cnt stops at the last bit; it is reloaded on the next accept
                    if (!last_bit) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        d      <= res_next;
                        borrow <= br_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
module tb_serial_subtractor_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, d8;
    logic       busy8, done8, borrow8;

    // WIDTH=1 instance
    logic       start1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0, d1;
    logic       busy1, done1, borrow1;

    // WIDTH=16 instance
    logic        start16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0, d16;
    logic        busy16, done16, borrow16;

    int checks = 0;
    int errors = 0;

    serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .d(d8), .borrow(borrow8)
    );

    serial_subtractor_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .d(d1), .borrow(borrow1)
    );

    serial_subtractor_ctrl #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .d(d16), .borrow(borrow16)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned subtraction with one extra bit for the borrow.
    function automatic logic [16:0] ref_sub(input logic [15:0] ra, input logic [15:0] rb);
        return {1'b0, ra} - {1'b0, rb};
    endfunction

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input string tag);
        logic [16:0] exp;
        exp = ref_sub({8'h0, ta}, {8'h0, tb_});
        a8 = ta; b8 = tb_; start8 = 1'b1;
        step();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_busy"}, 32'(busy8), 32'd1);
            chk({tag, "_nodone"}, 32'(done8), 32'd0);
            step();
        end
        chk({tag, "_done"}, 32'(done8), 32'd1);
        chk({tag, "_busy_lo"}, 32'(busy8), 32'd0);
        chk({tag, "_d"}, 32'(d8), 32'(exp[7:0]));
        chk({tag, "_borrow"}, 32'(borrow8), 32'(exp[8]));
        step();
        chk({tag, "_done_1cyc"}, 32'(done8), 32'd0);
    endtask

    task automatic run1(input logic ta, input logic tb_, input string tag);
        a1 = ta; b1 = tb_; start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk({tag, "_busy"}, 32'(busy1), 32'd1);
        chk({tag, "_nodone"}, 32'(done1), 32'd0);
        step();
        chk({tag, "_done"}, 32'(done1), 32'd1);
        chk({tag, "_d"}, 32'(d1), 32'(ta ^ tb_));
        chk({tag, "_borrow"}, 32'(borrow1), 32'(ta < tb_));
        step();
    endtask

    initial begin
        int   ndone, prev, cyc, pulses;
        logic bad_overlap, bad_double, last_done;
        logic [7:0]  cap_d;
        logic        cap_b;
        logic [16:0] exp16;
        logic        got;

        // Reset state
        step(); step();
        rst = 1'b0;
        chk("rst_busy8", 32'(busy8), 32'd0);
        chk("rst_done8", 32'(done8), 32'd0);
        chk("rst_d8", 32'(d8), 32'd0);
        chk("rst_borrow8", 32'(borrow8), 32'd0);
        chk("rst_d16", 32'(d16), 32'd0);

        // Directed WIDTH=8 cases
        run8(8'h5A, 8'h3C, "w8_5a_3c");
        run8(8'h00, 8'h01, "w8_00_01");
        run8(8'hFF, 8'hFF, "w8_ff_ff");
        run8(8'h80, 8'h7F, "w8_80_7f");

        // start during RUN is ignored, operand changes do not matter
        a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step(); step();
        a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        step();
        start8 = 1'b0;
        ndone = 0; cap_d = '0; cap_b = 1'b1;
        bad_overlap = 1'b0; bad_double = 1'b0; last_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (done8) begin ndone++; cap_d = d8; cap_b = borrow8; end
            if (done8 && busy8) bad_overlap = 1'b1;
            if (done8 && last_done) bad_double = 1'b1;
            last_done = done8;
            step();
        end
        chk("ign_ndone", 32'(ndone), 32'd1);
        chk("ign_d", 32'(cap_d), 32'h0F);
        chk("ign_borrow", 32'(cap_b), 32'd0);
        chk("ign_overlap", 32'(bad_overlap), 32'd0);

        // start held high: one result every WIDTH+2 cycles
        a8 = 8'h64; b8 = 8'h32; start8 = 1'b1;
        prev = -1; pulses = 0;
        bad_overlap = 1'b0; bad_double = 1'b0; last_done = 1'b0;
        for (int i = 0; i < 45; i++) begin
            step();
            if (done8) begin
                pulses++;
                chk("cont_d", 32'(d8), 32'h32);
                chk("cont_borrow", 32'(borrow8), 32'd0);
                if (prev >= 0) chk("cont_period", 32'(i - prev), 32'd10);
                prev = i;
            end
            if (done8 && busy8) bad_overlap = 1'b1;
            if (done8 && last_done) bad_double = 1'b1;
            last_done = done8;
        end
        start8 = 1'b0;
        chk("cont_pulses", 32'(pulses), 32'd4);
        chk("cont_overlap", 32'(bad_overlap), 32'd0);
        chk("cont_double", 32'(bad_double), 32'd0);
        for (int i = 0; i < 12; i++) step();

        // Reset abort in RUN cycle 4
        a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step(); step(); step();
        chk("abort_pre_busy", 32'(busy8), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_d", 32'(d8), 32'd0);
        chk("abort_borrow", 32'(borrow8), 32'd0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) ndone++;
            step();
        end
        chk("abort_nodone", 32'(ndone), 32'd0);
        run8(8'h5A, 8'h3C, "w8_after_abort");

        // WIDTH=1: registered half subtractor
        run1(1'b0, 1'b0, "w1_00");
        run1(1'b0, 1'b1, "w1_01");
        run1(1'b1, 1'b0, "w1_10");
        run1(1'b1, 1'b1, "w1_11");

        // WIDTH=16 random sweep
        for (int n = 0; n < 1000; n++) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            if (n == 0) begin a16 = 16'h0000; b16 = 16'hFFFF; end
            if (n == 1) begin a16 = 16'hFFFF; b16 = 16'h0000; end
            exp16 = ref_sub(a16, b16);
            start16 = 1'b1;
            step();
            start16 = 1'b0;
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            got = 1'b0; cyc = 0;
            for (int i = 1; i <= 20 && !got; i++) begin
                step();
                if (done16) begin got = 1'b1; cyc = i; end
            end
            if (!got) begin
                chk("w16_timeout", 32'd0, 32'd1);
            end else begin
                chk("w16_latency", 32'(cyc), 32'd16);
                chk("w16_result", 32'({borrow16, d16}), 32'(exp16));
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
